// File: rtl/bitwise_checker.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_checker
//  Purpose  : Drives a check run over NUM_VECTORS vectors, compares the
//             bitwise unit result x against AND/OR/XOR/NOT of the latched
//             operands, and keeps saturating pass/fail counts.
//             Optional first-fail capture: define BITWISE_CHECKER_CAPTURE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bitwise_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VECTORS   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       valid,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    input  logic [7:0] x,
    output logic       busy,
    output logic       done,
    output logic       all_pass,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt,
    output logic [7:0] first_fail_a,
    output logic [7:0] first_fail_b,
    output logic [7:0] first_fail_x
);

    localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [9:0] c_LAST_IDX    = 10'(NUM_VECTORS - 1);
    localparam logic [7:0] c_SAT         = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_VEC = 3'd1,
        S_SETTLE   = 3'd2,
        S_CHECK    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_settle_cnt;
    logic [9:0] r_vec_idx;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [1:0] r_op;
    logic [7:0] r_pass;
    logic [7:0] r_fail;
    logic [7:0] w_expected;
    logic       w_match;
    logic       w_start_run;
    logic       w_last_vec;

    always_comb begin
        w_expected = 8'h00;
        case (r_op)
            2'b00:   w_expected = r_a & r_b;
            2'b01:   w_expected = r_a | r_b;
            2'b10:   w_expected = r_a ^ r_b;
            default: w_expected = ~r_a;
        endcase
    end

    assign w_match     = (x == w_expected);
    assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_vec  = (r_vec_idx == c_LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WAIT_VEC;
            end
            S_WAIT_VEC: begin
                busy = 1'b1;
                if (valid) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (r_settle_cnt == 8'd0) w_next = S_CHECK;
            end
            S_CHECK: begin
                busy   = 1'b1;
                w_next = w_last_vec ? S_DONE : S_WAIT_VEC;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_next = S_WAIT_VEC;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= 8'd0;
            r_vec_idx    <= 10'd0;
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_op         <= 2'd0;
            r_pass       <= 8'd0;
            r_fail       <= 8'd0;
        end else begin
            if (w_start_run) begin
                r_pass    <= 8'd0;
                r_fail    <= 8'd0;
                r_vec_idx <= 10'd0;
            end
            if ((r_state == S_WAIT_VEC) && valid) begin
                r_a          <= a;
                r_b          <= b;
                r_op         <= op;
                r_settle_cnt <= c_SETTLE_LOAD;
            end
            if ((r_state == S_SETTLE) && (r_settle_cnt != 8'd0)) begin
                r_settle_cnt <= r_settle_cnt - 8'd1;
            end
            // x is only ever looked at here, one cycle after settling ends
            if (r_state == S_CHECK) begin
                if (w_match) begin
                    if (r_pass != c_SAT) r_pass <= r_pass + 8'd1;
                end else begin
                    if (r_fail != c_SAT) r_fail <= r_fail + 8'd1;
                end
                if (!w_last_vec) r_vec_idx <= r_vec_idx + 10'd1;
            end
        end
    end

    assign pass_cnt = r_pass;
    assign fail_cnt = r_fail;
    assign all_pass = done && (r_fail == 8'd0);

`ifdef BITWISE_CHECKER_CAPTURE_EN
    logic [7:0] r_ff_a;
    logic [7:0] r_ff_b;
    logic [7:0] r_ff_x;

    // fail count still zero marks the first mismatch of the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ff_a <= 8'd0;
            r_ff_b <= 8'd0;
            r_ff_x <= 8'd0;
        end else if (w_start_run) begin
            r_ff_a <= 8'd0;
            r_ff_b <= 8'd0;
            r_ff_x <= 8'd0;
        end else if ((r_state == S_CHECK) && !w_match && (r_fail == 8'd0)) begin
            r_ff_a <= r_a;
            r_ff_b <= r_b;
            r_ff_x <= x;
        end
    end

    assign first_fail_a = r_ff_a;
    assign first_fail_b = r_ff_b;
    assign first_fail_x = r_ff_x;
`else
    assign first_fail_a = 8'h00;
    assign first_fail_b = 8'h00;
    assign first_fail_x = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitwise_checker
//  Purpose  : Scoreboard bench for bitwise_checker (default instance plus a
//             NUM_VECTORS=300 / SETTLE_CYCLES=1 instance for saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_checker;

    localparam int SETTLE = 4;

    logic       clk, reset, start, valid;
    logic [7:0] a, b, x;
    logic [1:0] op;
    logic       busy, done, all_pass;
    logic [7:0] pass_cnt, fail_cnt, first_fail_a, first_fail_b, first_fail_x;

    logic       start_s, valid_s;
    logic [7:0] a_s, b_s, x_s;
    logic [1:0] op_s;
    logic       busy_s, done_s, all_pass_s;
    logic [7:0] pass_s, fail_s, ffa_s, ffb_s, ffx_s;

    int total = 0;
    int bad   = 0;
    bit sb[$];
    int mdl_pass, mdl_fail;

    bitwise_checker #(.SETTLE_CYCLES(SETTLE), .NUM_VECTORS(10)) dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid),
        .a(a), .b(b), .op(op), .x(x),
        .busy(busy), .done(done), .all_pass(all_pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b), .first_fail_x(first_fail_x)
    );

    bitwise_checker #(.SETTLE_CYCLES(1), .NUM_VECTORS(300)) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .valid(valid_s),
        .a(a_s), .b(b_s), .op(op_s), .x(x_s),
        .busy(busy_s), .done(done_s), .all_pass(all_pass_s),
        .pass_cnt(pass_s), .fail_cnt(fail_s),
        .first_fail_a(ffa_s), .first_fail_b(ffb_s), .first_fail_x(ffx_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_x(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic [1:0] rop);
        case (rop)
            2'b00:   return ra & rb;
            2'b01:   return ra | rb;
            2'b10:   return ra ^ rb;
            default: return ~ra;
        endcase
    endfunction

    task automatic model_update();
        bit ok;
        ok = sb.pop_front();
        if (ok) mdl_pass = (mdl_pass == 255) ? 255 : mdl_pass + 1;
        else    mdl_fail = (mdl_fail == 255) ? 255 : mdl_fail + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; valid = 1'b0; start_s = 1'b0; valid_s = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mdl_pass = 0; mdl_fail = 0;
        sb.delete();
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        mdl_pass = 0; mdl_fail = 0;
    endtask

    // Returns half a cycle before the check edge; with glitch set, valid is
    // re-pulsed and x wobbles during settling before landing on vx.
    task automatic send_vec(input logic [7:0] va, input logic [7:0] vb,
                            input logic [1:0] vop, input logic [7:0] vx, input bit glitch);
        @(negedge clk);
        valid = 1'b1; a = va; b = vb; op = vop; x = vx;
        sb.push_back(ref_x(va, vb, vop) == vx);
        @(negedge clk);
        valid = 1'b0; a = ~va; b = va ^ vb; op = vop + 2'd1;
        if (glitch) x = ~vx;
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk);
            if (glitch) begin
                case (i)
                    0: begin valid = 1'b1; a = 8'h00; b = 8'h00; op = 2'b00; x = vx ^ 8'h5A; end
                    1: begin valid = 1'b0; x = ~vx; end
                    2: x = vx;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; valid = 1'b0; a = 0; b = 0; op = 0; x = 0;
        start_s = 1'b0; valid_s = 1'b0; a_s = 0; b_s = 0; op_s = 0; x_s = 0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || all_pass !== 1'b0) begin
            bad++; $display("FAIL reset_flags busy=%b done=%b all_pass=%b want 0", busy, done, all_pass); end
        total++; if (pass_cnt !== 8'h00 || fail_cnt !== 8'h00) begin
            bad++; $display("FAIL reset_counts pass=%h fail=%h want 00", pass_cnt, fail_cnt); end
        total++; if ({first_fail_a, first_fail_b, first_fail_x} !== 24'h0) begin
            bad++; $display("FAIL reset_first_fail got=%h want 000000", {first_fail_a, first_fail_b, first_fail_x}); end
        @(negedge clk); reset = 1'b0;
        mdl_pass = 0; mdl_fail = 0;
    endtask

    task automatic test_basic_and();
        do_start();
        send_vec(8'h81, 8'h84, 2'b00, 8'h80, 1'b0);
        total++; if (pass_cnt !== 8'd0) begin
            bad++; $display("FAIL and_latency_early pass=%0d want 0", pass_cnt); end
        @(negedge clk);
        model_update();
        total++; if (pass_cnt !== 8'(mdl_pass) || fail_cnt !== 8'(mdl_fail)) begin
            bad++; $display("FAIL and_counts pass=%0d fail=%0d want %0d/%0d", pass_cnt, fail_cnt, mdl_pass, mdl_fail); end
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL and_busy busy=%b done=%b want 1/0", busy, done); end
    endtask

    task automatic test_or_run();
        logic [7:0] va, vb;
        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                @(negedge clk); start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            va = 8'($urandom); vb = 8'($urandom);
            send_vec(va, vb, 2'b01, va | vb, 1'b0);
            @(negedge clk);
            model_update();
            total++; if (pass_cnt !== 8'(mdl_pass) || fail_cnt !== 8'(mdl_fail)) begin
                bad++; $display("FAIL or_vec%0d pass=%0d fail=%0d want %0d/%0d", i, pass_cnt, fail_cnt, mdl_pass, mdl_fail); end
        end
        total++; if (done !== 1'b1 || all_pass !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL or_done done=%b all_pass=%b busy=%b want 1/1/0", done, all_pass, busy); end
        total++; if (pass_cnt !== 8'd10) begin
            bad++; $display("FAIL or_total pass=%0d want 10", pass_cnt); end
    endtask

    task automatic test_capture();
        logic [7:0] va[4] = '{8'hFF, 8'h0F, 8'h01, 8'h3C};
        logic [7:0] vb[4] = '{8'h81, 8'hAA, 8'h02, 8'h0F};
        logic [1:0] vo[4] = '{2'b01, 2'b11, 2'b00, 2'b10};
        logic [7:0] vx[4] = '{8'h00, 8'hF0, 8'hFF, 8'h33};
        logic [23:0] want_ff;
        do_start();
        total++; if (pass_cnt !== 8'd0 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_clear pass=%0d done=%b busy=%b want 0/0/1", pass_cnt, done, busy); end
        for (int i = 0; i < 4; i++) begin
            send_vec(va[i], vb[i], vo[i], vx[i], 1'b0);
            @(negedge clk);
            model_update();
            total++; if (pass_cnt !== 8'(mdl_pass) || fail_cnt !== 8'(mdl_fail)) begin
                bad++; $display("FAIL cap_vec%0d pass=%0d fail=%0d want %0d/%0d", i, pass_cnt, fail_cnt, mdl_pass, mdl_fail); end
        end
        total++; if (fail_cnt !== 8'd2) begin
            bad++; $display("FAIL cap_fail_cnt got=%0d want 2", fail_cnt); end
`ifdef BITWISE_CHECKER_CAPTURE_EN
        want_ff = 24'hFF_81_00;
`else
        want_ff = 24'h00_00_00;
`endif
        total++; if ({first_fail_a, first_fail_b, first_fail_x} !== want_ff) begin
            bad++; $display("FAIL cap_first_fail got=%h want %h", {first_fail_a, first_fail_b, first_fail_x}, want_ff); end
    endtask

    task automatic test_settle_glitch();
        do_reset();
        do_start();
        send_vec(8'hC3, 8'h5A, 2'b10, 8'h99, 1'b1);
        total++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
            bad++; $display("FAIL glitch_early pass=%0d fail=%0d want 0/0", pass_cnt, fail_cnt); end
        @(negedge clk);
        model_update();
        total++; if (pass_cnt !== 8'(mdl_pass) || fail_cnt !== 8'(mdl_fail)) begin
            bad++; $display("FAIL glitch_counts pass=%0d fail=%0d want %0d/%0d", pass_cnt, fail_cnt, mdl_pass, mdl_fail); end
    endtask

    task automatic test_reset_midsettle();
        @(negedge clk); valid = 1'b1; a = 8'h12; b = 8'h34; op = 2'b01; x = 8'h00;
        @(negedge clk); valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || all_pass !== 1'b0) begin
            bad++; $display("FAIL midsettle_reset pass=%0d fail=%0d busy=%b done=%b ap=%b want all 0",
                            pass_cnt, fail_cnt, busy, done, all_pass); end
        @(negedge clk); reset = 1'b0;
        sb.delete(); mdl_pass = 0; mdl_fail = 0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL no_autostart busy=%b want 0", busy); end
        @(negedge clk); start = 1'b1; valid = 1'b1; a = 8'h11; b = 8'h22; op = 2'b00; x = 8'h55;
        @(negedge clk); start = 1'b0; valid = 1'b0;
        repeat (SETTLE + 3) @(negedge clk);
        total++; if (busy !== 1'b1 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
            bad++; $display("FAIL start_valid busy=%b pass=%0d fail=%0d want 1/0/0", busy, pass_cnt, fail_cnt); end
        send_vec(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0);
        @(negedge clk);
        model_update();
        total++; if (pass_cnt !== 8'(mdl_pass) || fail_cnt !== 8'(mdl_fail)) begin
            bad++; $display("FAIL fresh_run pass=%0d fail=%0d want %0d/%0d", pass_cnt, fail_cnt, mdl_pass, mdl_fail); end
    endtask

    task automatic test_saturate();
        int fail_mdl;
        do_reset();
        fail_mdl = 0;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int i = 0; i < 300; i++) begin
            valid_s = 1'b1; a_s = 8'(i); b_s = 8'($urandom); op_s = 2'(i);
            x_s = ~ref_x(a_s, b_s, op_s);
            @(negedge clk); valid_s = 1'b0;
            @(negedge clk);
            @(negedge clk);
            fail_mdl = (fail_mdl == 255) ? 255 : fail_mdl + 1;
            if (i == 99 || i == 254 || i == 280) begin
                total++; if (fail_s !== 8'(fail_mdl)) begin
                    bad++; $display("FAIL sat_progress vec=%0d fail=%0d want %0d", i, fail_s, fail_mdl); end
            end
        end
        for (int k = 0; k < 10 && done_s !== 1'b1; k++) @(negedge clk);
        total++; if (done_s !== 1'b1 || busy_s !== 1'b0 || all_pass_s !== 1'b0) begin
            bad++; $display("FAIL sat_done done=%b busy=%b all_pass=%b want 1/0/0", done_s, busy_s, all_pass_s); end
        total++; if (fail_s !== 8'hFF || pass_s !== 8'h00) begin
            bad++; $display("FAIL sat_counts fail=%h pass=%h want FF/00", fail_s, pass_s); end
    endtask

    initial begin
        test_reset();
        test_basic_and();
        test_or_run();
        test_capture();
        test_settle_glitch();
        test_reset_midsettle();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_checker.md
BITWISE_CHECKER -- requirements
Module: bitwise_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, number of cycles to wait after a vector is accepted before sampling x; legal range 1..255.
REQ-002 Parameter: NUM_VECTORS, default 10, number of vectors in one check run; legal range 1..1023.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: start  input  1  single-cycle pulse that begins a run.
REQ-007 Port: valid  input  1  a, b and op carry a new vector this cycle.
REQ-008 Port: a, b  input  8 each  operands as applied to the bitwise unit.
REQ-009 Port: op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT a.
REQ-010 Port: x  input  8  result from the bitwise unit under check.
REQ-011 Port: busy  output  1  a run is in progress.
REQ-012 Port: done  output  1  the run has completed; held until the next start or reset.
REQ-013 Port: all_pass  output  1  done=1 and fail_cnt=0.
REQ-014 Port: pass_cnt, fail_cnt  output  8 each  saturating result counters.
REQ-015 Port: first_fail_a, first_fail_b, first_fail_x  output  8 each  operands and result of the first failing vector.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_VEC, SETTLE, CHECK and DONE.
REQ-017 IDLE or DONE, on start=1: clear pass_cnt, fail_cnt and vec_idx, clear done, move to WAIT_VEC.
REQ-018 WAIT_VEC, on valid=1: latch a, b and op, load the settle counter with SETTLE_CYCLES-1, move to SETTLE.
REQ-019 SETTLE: decrement the settle counter each cycle; at 0, move to CHECK.
REQ-020 CHECK (one cycle): compare x against the expected value computed from the latched a, b and op.
- Match: pass_cnt increments.
- Mismatch: fail_cnt increments.
- Both counters saturate at 8'hFF.
REQ-021 CHECK exit: if vec_idx=NUM_VECTORS-1, move to DONE; otherwise increment vec_idx and move to WAIT_VEC.
REQ-022 Latency: valid accepted at edge E0, x sampled and counters updated at edge E0+SETTLE_CYCLES+1.
REQ-023 x SHALL be sampled only in CHECK; changes in x during SETTLE have no effect.
REQ-024 The following inputs SHALL be ignored:
- valid outside WAIT_VEC;
- start while busy;
- a, b and op except at the cycle a vector is accepted.
REQ-025 busy=1 in WAIT_VEC, SETTLE and CHECK; done=1 only in DONE.
REQ-026 If start and valid are both high in IDLE, start is taken and valid is ignored that cycle.
REQ-027 The expected value SHALL be computed at the full 8-bit width with no sign extension; NOT a is ~a and b is ignored.

Reset
REQ-028 On reset, from any state including mid-SETTLE or CHECK:
- the FSM returns to IDLE;
- all counters, vec_idx, busy, done, all_pass and all first_fail_* outputs are 0;
- the latched operands are cleared.
REQ-029 Reset deassertion SHALL NOT start a run; an explicit start is required.

Configuration
REQ-030 Macro BITWISE_CHECKER_CAPTURE_EN defined: on the first mismatch of a run, latch the operands a and b and the sampled x into first_fail_a/b/x; hold them until the next start or reset.
REQ-031 Macro BITWISE_CHECKER_CAPTURE_EN undefined: tie first_fail_* to 8'h00 and infer no capture registers; all other behaviour is unchanged.

Verification
REQ-032 Defaults; start; vector op=00, a=8'h81, b=8'h84, x=8'h80 -> pass_cnt=1 at edge E0+5, fail_cnt=0.
REQ-033 Ten vectors, op=01 with correct x -> done=1 and all_pass=1 after the tenth CHECK, pass_cnt=10, busy=0.
REQ-034 Capture enabled; op=01, a=8'hFF, b=8'h81, x=8'h00; a later fail with a=8'h01 -> fail_cnt=2, first_fail_a=FF, first_fail_b=81, first_fail_x=00.
REQ-035 valid pulsed during SETTLE, and x toggled during SETTLE then settled correct -> the extra vector is ignored and a pass is counted.
REQ-036 NUM_VECTORS=300, every vector failing -> fail_cnt saturates at 8'hFF and done=1.
REQ-037 Reset asserted mid-SETTLE -> all outputs are 0 immediately; a following start runs a fresh pass with counters at 0.
